// File: rtl/mem_bus_responder.sv
// Memory-side responder: boot ROM overlay, WRAM and boot-disable register.
// Define ECHO_RAM_EN to alias 0xE000-0xFDFF onto WRAM.
module mem_bus_responder #(
    parameter int unsigned RAM_AW        = 13,
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic [15:0] BOOT_DIS_ADDR = 16'hFF50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        mem_cs,
    input  logic        mem_oe,
    input  logic        mem_we,
    output logic [7:0]  boot_addr,
    input  logic [7:0]  boot_data,
    output logic        mem_ready,
    output logic        bus_err,
    output logic        boot_en
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        RG_BOOT,
        RG_WRAM,
        RG_BDIS,
        RG_NONE
    } region_t;

    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be 1..4");
    end

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        boot_en_q, boot_en_d;

    logic [7:0]  wram [0:(1 << RAM_AW) - 1];
    logic        wram_we;
    logic [7:0]  rd_mux;
    logic        drive_en;
    region_t     rg_q, rg_in;

    function automatic region_t decode(input logic [15:0] a,
                                       input logic        ben);
        region_t r;
        r = RG_NONE;
        if (a == BOOT_DIS_ADDR) begin
            r = RG_BDIS;
        end else if (ben && a[15:8] == 8'h00) begin
            r = RG_BOOT;
        end else if (a[15:13] == 3'b110) begin
            r = RG_WRAM;
`ifdef ECHO_RAM_EN
        end else if (a >= 16'hE000 && a <= 16'hFDFF) begin
            r = RG_WRAM;
`endif
        end
        return r;
    endfunction

    assign rg_q  = decode(addr_q, boot_en_q);
    assign rg_in = decode(addr_bus, boot_en_q);

    // Echo addresses share the low RAM_AW bits with their WRAM twin.
    always_comb begin
        rd_mux = 8'hFF;
        unique case (rg_q)
            RG_BOOT: rd_mux = boot_data;
            RG_WRAM: rd_mux = wram[addr_q[RAM_AW-1:0]];
            RG_BDIS: rd_mux = {7'h7F, ~boot_en_q};
            default: rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_cs) begin
                    if (mem_oe && mem_we) begin
                        state_d = RELEASE;
                    end else if (mem_oe) begin
                        state_d = RD_WAIT;
                    end else if (mem_we) begin
                        state_d = WR;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                if (!(mem_cs && mem_oe)) begin
                    state_d = IDLE;
                end
            end
            WR:      state_d = RELEASE;
            RELEASE: begin
                if (!mem_cs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = 1'b0;
        drive_en  = 1'b0;
        boot_addr = addr_q[7:0];
        unique case (state_q)
            IDLE:     boot_addr = addr_bus[7:0];
            RD_DRIVE: begin
                mem_ready = 1'b1;
                drive_en  = !mem_we;
            end
            WR:       mem_ready = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        boot_en_d = boot_en_q;
        wram_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_cs) begin
                    addr_d    = addr_bus;
                    wdata_d   = data_bus;
                    cnt_d     = LAT_M1;
                    bus_err_d = (mem_oe && mem_we) ||
                                (mem_we && !mem_oe && rg_in == RG_NONE);
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d   = rd_mux;
                    bus_err_d = (rg_q == RG_NONE);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WR: begin
                wram_we = (rg_q == RG_WRAM);
                if (rg_q == RG_BDIS && wdata_q != 8'h00) begin
                    boot_en_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            boot_en_q <= 1'b1;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            boot_en_q <= boot_en_d;
        end
    end

    // Contents survive reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (wram_we && !rst) begin
            wram[addr_q[RAM_AW-1:0]] <= wdata_q;
        end
    end

    assign data_bus = drive_en ? rdata_q : {8{1'bz}};
    assign bus_err  = bus_err_q;
    assign boot_en  = boot_en_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder at READ_LATENCY 1 and 3.
// Released bus reads as 0x00 through pulldowns.
`timescale 1ns/1ps
module tb_mem_bus_responder;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic        err;
        logic [31:0] due;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr_bus = '0;
    logic        mem_cs = 1'b0;
    logic        mem_oe = 1'b0;
    logic        mem_we = 1'b0;
    logic [7:0]  tb_data = '0;
    logic        tb_drive = 1'b0;
    wire  [7:0]  bus0;
    wire  [7:0]  bus1;
    logic [7:0]  baddr0, baddr1;
    logic [7:0]  bdata0 = '0;
    logic [7:0]  bdata1 = '0;
    logic        rdy0, rdy1, err0, err1, ben0, ben1;
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    item_t       q0[$];
    item_t       q1[$];

    assign bus0 = tb_drive ? tb_data : 8'hzz;
    assign bus1 = tb_drive ? tb_data : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown pd0 (bus0[i]);
        pulldown pd1 (bus1[i]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h00) ? 8'h31 : (a ^ 8'hA0);
    endfunction

    always @(posedge clk) begin
        bdata0 <= rom(baddr0);
        bdata1 <= rom(baddr1);
    end

    mem_bus_responder #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(bus0),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .boot_addr(baddr0), .boot_data(bdata0),
        .mem_ready(rdy0), .bus_err(err0), .boot_en(ben0)
    );

    mem_bus_responder #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(bus1),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .boot_addr(baddr1), .boot_data(bdata1),
        .mem_ready(rdy1), .bus_err(err1), .boot_en(ben1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic rdy, input logic err,
                       input logic [7:0] bus);
        item_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL dut%0d unexpected response: rdy=%0b err=%0b",
                     id, rdy, err);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("dut%0d cycle", id), cyc, e.due);
        check($sformatf("dut%0d bus_err", id), {31'd0, err}, {31'd0, e.err});
        check($sformatf("dut%0d ready", id), {31'd0, rdy},
              {31'd0, e.kind != K_ERR});
        if (e.kind == K_RD) begin
            check($sformatf("dut%0d data", id), {24'd0, bus}, {24'd0, e.data});
        end
    endtask

    always @(negedge clk) begin
        if ((rdy0 && !prev0) || (err0 && !rdy0)) mon(0, rdy0, err0, bus0);
        if ((rdy1 && !prev1) || (err1 && !rdy1)) mon(1, rdy1, err1, bus1);
        prev0 = rdy0;
        prev1 = rdy1;
    end

    task automatic push(input logic [1:0] k, input logic [7:0] d,
                        input logic er);
        item_t e;
        e.kind = k;
        e.data = d;
        e.err  = er;
        e.due  = cyc + 1 + ((k == K_RD) ? 1 : 0);
        q0.push_back(e);
        e.due  = cyc + 1 + ((k == K_RD) ? 3 : 0);
        q1.push_back(e);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] exp,
                           input logic er, input bit rst_mid);
        bit ok;
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        mem_we = 1'b0;
        addr_bus = a;
        push(K_RD, exp, er);
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy0 && rdy1) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("read %h ready in time", a), {31'd0, ok}, 32'd1);
        if (rst_mid) begin
            rst = 1'b1;
            mem_cs = 1'b0;
            mem_oe = 1'b0;
            @(negedge clk);
            check("rst drive ready", {31'd0, rdy0}, 32'd0);
            check("rst drive ready3", {31'd0, rdy1}, 32'd0);
            check("rst drive bus_err", {31'd0, err0}, 32'd0);
            check("rst drive bus", {24'd0, bus0}, 32'd0);
            check("rst drive bus3", {24'd0, bus1}, 32'd0);
            check("rst drive boot_en", {31'd0, ben0}, 32'd1);
            check("rst drive boot_en3", {31'd0, ben1}, 32'd1);
            rst = 1'b0;
        end else begin
            addr_bus = a ^ 16'h1234;
            @(negedge clk);
            check($sformatf("hold %h", a), {24'd0, bus0}, {24'd0, exp});
            check($sformatf("hold3 %h", a), {24'd0, bus1}, {24'd0, exp});
            mem_cs = 1'b0;
            mem_oe = 1'b0;
            @(negedge clk);
            check("release bus", {24'd0, bus0}, 32'd0);
            check("release bus3", {24'd0, bus1}, 32'd0);
            check("release ready", {31'd0, rdy0}, 32'd0);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input logic er, input int hold);
        mem_cs = 1'b1;
        mem_we = 1'b1;
        mem_oe = 1'b0;
        addr_bus = a;
        tb_data = d;
        tb_drive = 1'b1;
        push(K_WR, 8'h00, er);
        repeat (hold) @(negedge clk);
        mem_cs = 1'b0;
        mem_we = 1'b0;
        tb_drive = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write_rst(input logic [15:0] a, input logic [7:0] d);
        mem_cs = 1'b1;
        mem_we = 1'b1;
        mem_oe = 1'b0;
        addr_bus = a;
        tb_data = d;
        tb_drive = 1'b1;
        push(K_WR, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mem_cs = 1'b0;
        mem_we = 1'b0;
        tb_drive = 1'b0;
        @(negedge clk);
        check("rst wr ready", {31'd0, rdy0}, 32'd0);
        check("rst wr bus", {24'd0, bus0}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic do_both(input logic [15:0] a);
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        mem_we = 1'b1;
        addr_bus = a;
        tb_drive = 1'b0;
        push(K_ERR, 8'h00, 1'b1);
        @(negedge clk);
        check("oe+we bus", {24'd0, bus0}, 32'd0);
        check("oe+we bus3", {24'd0, bus1}, 32'd0);
        mem_cs = 1'b0;
        mem_oe = 1'b0;
        mem_we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready", {31'd0, rdy0}, 32'd0);
        check("reset bus_err", {31'd0, err0}, 32'd0);
        check("reset boot_en", {31'd0, ben0}, 32'd1);
        check("reset bus", {24'd0, bus0}, 32'd0);
        rst = 1'b0;

        do_read(16'h0000, 8'h31, 1'b0, 0);
        do_read(16'h0005, 8'hA5, 1'b0, 0);
        do_write(16'hC123, 8'hA5, 1'b0, 1);
        do_read(16'hC123, 8'hA5, 1'b0, 0);
        do_write(16'hFF50, 8'h00, 1'b0, 1);
        check("boot_en after write 0", {31'd0, ben0}, 32'd1);
        do_read(16'hFF50, 8'hFE, 1'b0, 0);
        do_read(16'hA000, 8'hFF, 1'b1, 0);
        do_write(16'hC050, 8'h3C, 1'b0, 1);
        do_both(16'hC050);
        do_read(16'hC050, 8'h3C, 1'b0, 0);
        do_write(16'hC010, 8'h66, 1'b0, 1);
`ifdef ECHO_RAM_EN
        do_write(16'hE010, 8'h5A, 1'b0, 1);
        do_read(16'hC010, 8'h5A, 1'b0, 0);
        do_read(16'hE010, 8'h5A, 1'b0, 0);
`else
        do_write(16'hE010, 8'h5A, 1'b1, 1);
        do_read(16'hC010, 8'h66, 1'b0, 0);
        do_read(16'hE010, 8'hFF, 1'b1, 0);
`endif
        do_write(16'hA000, 8'h12, 1'b1, 1);
        do_write(16'h0010, 8'h12, 1'b0, 1);
        do_read(16'h0010, 8'hB0, 1'b0, 0);
        do_write(16'hC0FF, 8'h44, 1'b0, 3);
        do_read(16'hC0FF, 8'h44, 1'b0, 0);
        do_write(16'hFF50, 8'h01, 1'b0, 1);
        check("boot_en after disable", {31'd0, ben0}, 32'd0);
        check("boot_en3 after disable", {31'd0, ben1}, 32'd0);
        do_read(16'hFF50, 8'hFF, 1'b0, 0);
        do_read(16'h0000, 8'hFF, 1'b1, 0);
        do_write(16'h0000, 8'h12, 1'b1, 1);
        do_write(16'hC200, 8'h11, 1'b0, 1);
        do_read(16'hC200, 8'h11, 1'b0, 1);
        do_write_rst(16'hC200, 8'h77);
        do_read(16'hC200, 8'h11, 1'b0, 0);
        do_read(16'h0000, 8'h31, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard drained", q0.size() + q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
